csr_commit: RTL and testbench

- WB-stage initiator for the CSR file: the block that drives csr_re/csr_num/csr_we/csr_wmask/csr_wvalue, wb_ex/wb_ecode/wb_esubcode/wb_epc and ertn_flush.
- Accepts one retiring instruction per cycle from MEM over a valid/allowin handshake and resolves the final exception, folding in the sampled interrupt.
- Performs CSR accesses and the register-file writeback.
- On an exception or ertn, pulses a pipeline flush with the redirect PC, then discards in-flight wrong-path instructions for a fixed kill window.

---
 rtl/csr_commit_pkg.sv | 28 ++
 rtl/csr_commit.sv | 178 +++++++++++++++++
 tb/tb_csr_commit.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_commit_pkg.sv
// Shared constants for the WB-stage CSR commit block.
package csr_commit_pkg;

   // Exception codes
   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   // Bit positions inside the one-hot ms_op field {ertn, csrxchg, csrwr, csrrd}
   localparam int unsigned OP_W       = 4;
   localparam int unsigned OP_CSRRD   = 0;
   localparam int unsigned OP_CSRWR   = 1;
   localparam int unsigned OP_CSRXCHG = 2;
   localparam int unsigned OP_ERTN    = 3;

   // Width of the MEM->WB bundle at the default 14-bit CSR number:
   // pc, op, csr_num, rj, rkd, rf_we, dest, result, ex, ecode, esubcode
   localparam int unsigned BUNDLE_W = 32 + OP_W + 14 + 32 + 32 + 1 + 5 + 32 + 1 + 6 + 9;

   typedef enum logic [1:0] {
      StIdle,
      StCommit,
      StKill
   } state_e;

endpackage

// File: rtl/csr_commit.sv
// WB-stage commit: resolves the final exception, drives CSR accesses and the
// register-file writeback, and flushes the pipeline on exception or ertn.
module csr_commit
   import csr_commit_pkg::*;
#(
   parameter int unsigned KILL_CYCLES = 2,
   parameter int unsigned CSR_NUM_W   = 14
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ms_to_ws_valid,
   output logic                 ws_allowin,
   input  logic [31:0]          ms_pc,
   input  logic [OP_W-1:0]      ms_op,
   input  logic [CSR_NUM_W-1:0] ms_csr_num,
   input  logic [31:0]          ms_rj_value,
   input  logic [31:0]          ms_rkd_value,
   input  logic                 ms_rf_we,
   input  logic [4:0]           ms_dest,
   input  logic [31:0]          ms_result,
   input  logic                 ms_ex,
   input  logic [5:0]           ms_ecode,
   input  logic [8:0]           ms_esubcode,
   input  logic                 has_int,
   input  logic [31:0]          csr_rvalue,
   input  logic [31:0]          ex_entry,
   input  logic [31:0]          ertn_pc,
   output logic                 csr_re,
   output logic [CSR_NUM_W-1:0] csr_num,
   output logic                 csr_we,
   output logic [31:0]          csr_wmask,
   output logic [31:0]          csr_wvalue,
   output logic                 wb_ex,
   output logic [5:0]           wb_ecode,
   output logic [8:0]           wb_esubcode,
   output logic [31:0]          wb_epc,
   output logic                 ertn_flush,
   output logic                 flush,
   output logic [31:0]          flush_pc,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata
);

   state_e     state_q, state_d;
   logic [2:0] kill_cnt_q, kill_cnt_d;
   logic       accept, load, ex_f;

   // Held bundle
   logic [31:0]          pc_q, rj_q, rkd_q, result_q;
   logic [OP_W-1:0]      op_q;
   logic [CSR_NUM_W-1:0] csr_num_q;
   logic                 rf_we_q, ex_q;
   logic [4:0]           dest_q;
   logic [5:0]           ecode_q;
   logic [8:0]           esubcode_q;

   // WB retires every cycle, so it can always take a new bundle.
   assign ws_allowin = 1'b1;
   assign accept     = ms_to_ws_valid && ws_allowin;
   // Only bundles that will actually commit are captured; dropped ones leave no trace.
   assign load       = accept && (state_d == StCommit);

   // State and kill-window counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         kill_cnt_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         kill_cnt_q <= kill_cnt_d;
      end
   end

   // Capture the incoming MEM bundle
   always_ff @(posedge clk) begin
      if (load) begin
         pc_q       <= ms_pc;
         op_q       <= ms_op;
         csr_num_q  <= ms_csr_num;
         rj_q       <= ms_rj_value;
         rkd_q      <= ms_rkd_value;
         rf_we_q    <= ms_rf_we;
         dest_q     <= ms_dest;
         result_q   <= ms_result;
         ex_q       <= ms_ex;
         ecode_q    <= ms_ecode;
         esubcode_q <= ms_esubcode;
      end
   end

   // Commit decode: all side effects of the held bundle, same cycle
   always_comb begin
      ex_f        = 1'b0;
      csr_re      = 1'b0;
      csr_num     = '0;
      csr_we      = 1'b0;
      csr_wmask   = 32'h0;
      csr_wvalue  = 32'h0;
      wb_ex       = 1'b0;
      wb_ecode    = 6'h0;
      wb_esubcode = 9'h0;
      wb_epc      = 32'h0;
      ertn_flush  = 1'b0;
      flush       = 1'b0;
      flush_pc    = 32'h0;
      rf_we       = 1'b0;
      rf_waddr    = 5'h0;
      rf_wdata    = 32'h0;
      if (state_q == StCommit) begin
         // Interrupt outranks any earlier-stage exception and suppresses CSR/RF effects.
         ex_f = has_int || ex_q;
         if (ex_f) begin
            wb_ex       = 1'b1;
            wb_ecode    = has_int ? ECODE_INT : ecode_q;
            wb_esubcode = has_int ? 9'h0 : esubcode_q;
            wb_epc      = pc_q;
            flush       = 1'b1;
            flush_pc    = ex_entry;
         end else if (op_q[OP_ERTN]) begin
            ertn_flush = 1'b1;
            flush      = 1'b1;
            flush_pc   = ertn_pc;
         end else begin
            rf_we = rf_we_q && (dest_q != 5'd0);
            if (op_q[OP_CSRRD]) begin
               csr_re   = 1'b1;
               rf_wdata = csr_rvalue;
            end else if (op_q[OP_CSRWR] || op_q[OP_CSRXCHG]) begin
               // The destination register receives the old CSR value.
               csr_re     = 1'b1;
               csr_we     = 1'b1;
               csr_wmask  = op_q[OP_CSRXCHG] ? rj_q : 32'hFFFF_FFFF;
               csr_wvalue = rkd_q;
               rf_wdata   = csr_rvalue;
            end else begin
               rf_wdata = result_q;
            end
         end
         if (csr_re || csr_we) begin
            csr_num = csr_num_q;
         end
         if (rf_we) begin
            rf_waddr = dest_q;
         end
      end
   end

   // Next state: commit on accept, enter the kill window on flush
   always_comb begin
      state_d    = state_q;
      kill_cnt_d = kill_cnt_q;
      unique case (state_q)
         StIdle, StCommit: begin
            if (flush) begin
               state_d    = StKill;
               kill_cnt_d = 3'(KILL_CYCLES - 1);
            end else if (accept) begin
               state_d = StCommit;
            end else begin
               state_d = StIdle;
            end
         end
         StKill: begin
            if (kill_cnt_q == 3'd0) begin
               state_d = StIdle;
            end else begin
               kill_cnt_d = kill_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d    = StIdle;
            kill_cnt_d = 3'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_csr_commit.sv
// Scoreboard bench for csr_commit: stimulus pushes expected commit events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_csr_commit;
   import csr_commit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [3:0]  ms_op;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_rj_value, ms_rkd_value;
   logic        ms_rf_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_result;
   logic        ms_ex;
   logic [5:0]  ms_ecode;
   logic [8:0]  ms_esubcode;
   logic        has_int;
   logic [31:0] csr_rvalue, ex_entry, ertn_pc;
   logic        csr_re;
   logic [13:0] csr_num;
   logic        csr_we;
   logic [31:0] csr_wmask, csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_epc;
   logic        ertn_flush, flush;
   logic [31:0] flush_pc;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always #5 clk = ~clk;

   csr_commit #(
      .KILL_CYCLES(2),
      .CSR_NUM_W  (14)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ms_to_ws_valid(ms_to_ws_valid),
      .ws_allowin    (ws_allowin),
      .ms_pc         (ms_pc),
      .ms_op         (ms_op),
      .ms_csr_num    (ms_csr_num),
      .ms_rj_value   (ms_rj_value),
      .ms_rkd_value  (ms_rkd_value),
      .ms_rf_we      (ms_rf_we),
      .ms_dest       (ms_dest),
      .ms_result     (ms_result),
      .ms_ex         (ms_ex),
      .ms_ecode      (ms_ecode),
      .ms_esubcode   (ms_esubcode),
      .has_int       (has_int),
      .csr_rvalue    (csr_rvalue),
      .ex_entry      (ex_entry),
      .ertn_pc       (ertn_pc),
      .csr_re        (csr_re),
      .csr_num       (csr_num),
      .csr_we        (csr_we),
      .csr_wmask     (csr_wmask),
      .csr_wvalue    (csr_wvalue),
      .wb_ex         (wb_ex),
      .wb_ecode      (wb_ecode),
      .wb_esubcode   (wb_esubcode),
      .wb_epc        (wb_epc),
      .ertn_flush    (ertn_flush),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata)
   );

   typedef struct packed {
      logic        allowin;
      logic        csr_re;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic        wb_ex;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] epc;
      logic        ertn_flush;
      logic        flush;
      logic [31:0] flush_pc;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } obs_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  op;
      logic [13:0] num;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        rfwe;
      logic [4:0]  dest;
      logic [31:0] result;
      logic        ex;
      logic [5:0]  ecode;
      logic [8:0]  esub;
   } bundle_t;

   typedef struct {
      string name;
      obs_t  o;
   } exp_t;

   localparam logic [3:0] OpNone = 4'b0000, OpRd = 4'b0001, OpWr = 4'b0010;
   localparam logic [3:0] OpXchg = 4'b0100, OpErtn = 4'b1000;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic obs_t observe();
      obs_t o;
      o = '{ws_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, wb_ecode,
            wb_esubcode, wb_epc, ertn_flush, flush, flush_pc, rf_we, rf_waddr, rf_wdata};
      return o;
   endfunction

   function automatic obs_t base();
      obs_t o;
      o = '0;
      o.allowin = 1'b1;
      return o;
   endfunction

   function automatic bundle_t mkb(input logic [31:0] pc, input logic [3:0] op,
                                   input logic [13:0] num, input logic [31:0] rj,
                                   input logic [31:0] rkd, input logic rfwe,
                                   input logic [4:0] dest, input logic [31:0] result,
                                   input logic ex, input logic [5:0] ecode,
                                   input logic [8:0] esub);
      bundle_t b;
      b = '{pc, op, num, rj, rkd, rfwe, dest, result, ex, ecode, esub};
      return b;
   endfunction

   // rf_wdata is only meaningful while rf_we is set
   function automatic void check(input string name, input obs_t act, input obs_t exp);
      obs_t a, e;
      a = act;
      e = exp;
      if (!e.rf_we) begin
         a.wdata = '0;
         e.wdata = '0;
      end
      n_assert++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void push(input string name, input obs_t o);
      exp_t e;
      e.name = name;
      e.o    = o;
      exp_q.push_back(e);
   endfunction

   // Monitor: any non-idle output pattern is a commit event that must match the queue head
   always @(negedge clk) begin
      obs_t a;
      exp_t e;
      a = observe();
      if (!reset && (a !== base())) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_event: got %h expected %h", a, base());
         end else begin
            e = exp_q.pop_front();
            check(e.name, a, e.o);
         end
      end
   end

   task automatic drive(input bundle_t b);
      ms_pc          = b.pc;
      ms_op          = b.op;
      ms_csr_num     = b.num;
      ms_rj_value    = b.rj;
      ms_rkd_value   = b.rkd;
      ms_rf_we       = b.rfwe;
      ms_dest        = b.dest;
      ms_result      = b.result;
      ms_ex          = b.ex;
      ms_ecode       = b.ecode;
      ms_esubcode    = b.esub;
      ms_to_ws_valid = 1'b1;
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      obs_t e;
      reset          = 1'b1;
      ms_to_ws_valid = 1'b0;
      drive_zero();
      has_int        = 1'b0;
      csr_rvalue     = 32'h0;
      ex_entry       = 32'h0;
      ertn_pc        = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observe(), base());
      reset = 1'b0;
      idle(1);

      // csrwr
      csr_rvalue = 32'h12;
      e = base();
      e.csr_re = 1; e.csr_num = 14'h30; e.csr_we = 1; e.wmask = 32'hFFFF_FFFF;
      e.wvalue = 32'hDEAD_BEEF; e.rf_we = 1; e.waddr = 5'd4; e.wdata = 32'h12;
      push("csrwr", e);
      drive(mkb(32'h1c00_0100, OpWr, 14'h30, 32'h0, 32'hDEAD_BEEF, 1, 5'd4, 32'h0, 0, 6'h0, 9'h0));
      idle(1);

      // csrxchg to r0: CSR write happens, no register write
      csr_rvalue = 32'h77;
      e = base();
      e.csr_re = 1; e.csr_num = 14'h31; e.csr_we = 1; e.wmask = 32'h0000_FF00;
      e.wvalue = 32'h1234_5678;
      push("csrxchg_r0", e);
      drive(mkb(32'h1c00_0104, OpXchg, 14'h31, 32'h0000_FF00, 32'h1234_5678, 1, 5'd0, 32'h0,
                0, 6'h0, 9'h0));
      idle(1);

      // csrrd
      csr_rvalue = 32'hA5A5_0001;
      e = base();
      e.csr_re = 1; e.csr_num = 14'h05; e.rf_we = 1; e.waddr = 5'd7; e.wdata = 32'hA5A5_0001;
      push("csrrd", e);
      drive(mkb(32'h1c00_0108, OpRd, 14'h05, 32'h0, 32'h0, 1, 5'd7, 32'h0, 0, 6'h0, 9'h0));
      idle(1);

      // csrrd to r0
      e = base();
      e.csr_re = 1; e.csr_num = 14'h06;
      push("csrrd_r0", e);
      drive(mkb(32'h1c00_010c, OpRd, 14'h06, 32'h0, 32'h0, 1, 5'd0, 32'h0, 0, 6'h0, 9'h0));
      idle(1);

      // Three ordinary instructions back to back
      for (int i = 1; i <= 3; i++) begin
         e = base();
         e.rf_we = 1; e.waddr = 5'(i); e.wdata = 32'h1000 + 32'(i);
         push($sformatf("ordinary_%0d", i), e);
      end
      for (int i = 1; i <= 3; i++) begin
         drive(mkb(32'h1c00_0110 + 32'(4 * i), OpNone, 14'h0, 32'h0, 32'h0, 1, 5'(i),
                   32'h1000 + 32'(i), 0, 6'h0, 9'h0));
      end
      idle(1);

      // Syscall, then two dropped bundles in the kill window, third commits
      ex_entry = 32'h1c00_8000;
      e = base();
      e.wb_ex = 1; e.ecode = ECODE_SYS; e.epc = 32'h1c00_0120; e.flush = 1;
      e.flush_pc = 32'h1c00_8000;
      push("syscall", e);
      drive(mkb(32'h1c00_0120, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd5, 32'h99, 1, ECODE_SYS,
                9'h0));
      idle(1);
      e = base();
      e.rf_we = 1; e.waddr = 5'd12; e.wdata = 32'hC0C0;
      push("after_kill", e);
      drive(mkb(32'h1c00_8000, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd10, 32'hA0A0, 0, 6'h0, 9'h0));
      drive(mkb(32'h1c00_8004, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd11, 32'hB0B0, 0, 6'h0, 9'h0));
      drive(mkb(32'h1c00_8008, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd12, 32'hC0C0, 0, 6'h0, 9'h0));
      idle(1);

      // Interrupt during csrwr: CSR write and RF write suppressed
      has_int    = 1'b1;
      csr_rvalue = 32'h55;
      e = base();
      e.wb_ex = 1; e.ecode = ECODE_INT; e.epc = 32'h1c00_0130; e.flush = 1;
      e.flush_pc = 32'h1c00_8000;
      push("int_csrwr", e);
      drive(mkb(32'h1c00_0130, OpWr, 14'h30, 32'h0, 32'hCAFE_F00D, 1, 5'd6, 32'h0, 0, 6'h0,
                9'h0));
      idle(1);
      has_int = 1'b0;
      idle(2);

      // Break on csrxchg with esubcode
      ex_entry = 32'h1c00_8040;
      e = base();
      e.wb_ex = 1; e.ecode = ECODE_BRK; e.esub = 9'h1A3; e.epc = 32'h1c00_0134; e.flush = 1;
      e.flush_pc = 32'h1c00_8040;
      push("brk_csrxchg", e);
      drive(mkb(32'h1c00_0134, OpXchg, 14'h31, 32'hFFFF_0000, 32'h1, 1, 5'd8, 32'h0, 1,
                ECODE_BRK, 9'h1A3));
      idle(3);

      // Interrupt with ertn: exception wins
      has_int  = 1'b1;
      ex_entry = 32'h1c00_8000;
      ertn_pc  = 32'h1c00_0200;
      e = base();
      e.wb_ex = 1; e.ecode = ECODE_INT; e.epc = 32'h1c00_0138; e.flush = 1;
      e.flush_pc = 32'h1c00_8000;
      push("int_ertn", e);
      drive(mkb(32'h1c00_0138, OpErtn, 14'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 6'h0, 9'h0));
      idle(3);

      // Interrupt over an earlier-stage ADEF
      e = base();
      e.wb_ex = 1; e.ecode = ECODE_INT; e.epc = 32'h1c00_013c; e.flush = 1;
      e.flush_pc = 32'h1c00_8000;
      push("int_over_adef", e);
      drive(mkb(32'h1c00_013c, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd9, 32'h5, 1, ECODE_ADEF,
                9'h1));
      idle(1);
      has_int = 1'b0;
      idle(2);

      // ertn, reset inside the kill window, then a fresh bundle commits
      e = base();
      e.ertn_flush = 1; e.flush = 1; e.flush_pc = 32'h1c00_0200;
      push("ertn", e);
      drive(mkb(32'h1c00_0140, OpErtn, 14'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 6'h0, 9'h0));
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      e = base();
      e.rf_we = 1; e.waddr = 5'd13; e.wdata = 32'hF00D;
      push("after_reset_kill", e);
      drive(mkb(32'h1c00_0200, OpNone, 14'h0, 32'h0, 32'h0, 1, 5'd13, 32'hF00D, 0, 6'h0, 9'h0));
      idle(1);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      n_assert++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending events expected 0 (next %s)",
                  exp_q.size(), exp_q[0].name);
      end
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   task automatic drive_zero();
      ms_pc        = 32'h0;
      ms_op        = 4'h0;
      ms_csr_num   = 14'h0;
      ms_rj_value  = 32'h0;
      ms_rkd_value = 32'h0;
      ms_rf_we     = 1'b0;
      ms_dest      = 5'h0;
      ms_result    = 32'h0;
      ms_ex        = 1'b0;
      ms_ecode     = 6'h0;
      ms_esubcode  = 9'h0;
   endtask

endmodule
